// File: rtl/mmio_led_pwm_pkg.sv
// Shared constants for the memory-mapped LED PWM controller: register window
// geometry, register byte offsets and the per-channel mode encodings.
package mmio_led_pwm_pkg;

  localparam int WIN_BITS  = 6;
  localparam int WIN_WORDS = 2 ** (WIN_BITS - 2);

  localparam logic [WIN_BITS-1:0] OFS_CTRL  = 6'h00;
  localparam logic [WIN_BITS-1:0] OFS_MODE  = 6'h04;
  localparam logic [WIN_BITS-1:0] OFS_DUTY0 = 6'h08;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_PWM   = 2'd2,
    MODE_BLINK = 2'd3
  } ledMode_e;

  // Word index inside the window for a byte offset.
  function automatic logic [WIN_BITS-3:0] wordIdx(input logic [WIN_BITS-1:0] ofs);
    return ofs[WIN_BITS-1:2];
  endfunction

endpackage

// File: rtl/mmio_led_pwm_channel.sv
// One LED channel: holds the active duty (reloaded only at the PWM wrap so a
// period is never cut short), the blink flop, and the registered active-low pin.
module led_pwm_channel
  import mmio_led_pwm_pkg::*;
#(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PWM_W-1:0] shadowDuty,
  input  logic [1:0]       mode,
  input  logic [PWM_W-1:0] cnt,
  input  logic             wrap,
  input  logic             en,
  output logic             nLed
);

  logic [PWM_W-1:0] activeDuty;
  logic             blinkState;
  logic             ledOn;

  // Active duty and blink flop only move at the period boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      activeDuty <= '0;
      blinkState <= 1'b0;
    end else if (wrap) begin
      activeDuty <= shadowDuty;
      blinkState <= ~blinkState;
    end
  end

  // Channel on condition from mode, counter position and blink phase.
  always_comb begin
    ledOn = 1'b0;
    if (en) begin
      case (ledMode_e'(mode))
        MODE_ON:    ledOn = 1'b1;
        MODE_PWM:   ledOn = (cnt < activeDuty);
        MODE_BLINK: ledOn = blinkState;
        default:    ledOn = 1'b0;
      endcase
    end
  end

  // Registered active-low pin driver.
  always_ff @(posedge clk) begin
    if (rst) begin
      nLed <= 1'b1;
    end else begin
      nLed <= ~ledOn;
    end
  end

endmodule

// File: rtl/mmio_led_pwm.sv
// Memory-mapped LED controller: bus decode, CTRL/MODE/shadow-duty registers,
// shared prescaler and PWM counter, and NCH channel instances.
module mmio_led_pwm
  import mmio_led_pwm_pkg::*;
#(
  parameter int          NCH       = 3,
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
  parameter int          PWM_W     = 8,
  parameter int          PRESC_W   = 16
) (
  input  logic           iwClk,
  input  logic           iwRst,
  input  logic [31:0]    iwReadAddr,
  input  logic [31:0]    iwWriteAddr,
  input  logic [31:0]    iwWriteData,
  input  logic [3:0]     iwWstrb,
  output logic [31:0]    owReadData,
  output logic [NCH-1:0] ownLed
);

  localparam int IDX_W = WIN_BITS - 2;
  localparam logic [IDX_W-1:0] IDX_CTRL = wordIdx(OFS_CTRL);
  localparam logic [IDX_W-1:0] IDX_MODE = wordIdx(OFS_MODE);
  localparam int IDX_DUTY0 = int'(wordIdx(OFS_DUTY0));

  logic                 ctrlEn;
  logic [PRESC_W-1:0]   ctrlPresc;
  logic [2*NCH-1:0]     modeReg;
  logic [PWM_W-1:0]     shadowDuty [NCH];

  logic [PRESC_W-1:0]   prescCnt;
  logic [PWM_W-1:0]     pwmCnt;
  logic                 tick;
  logic                 wrap;

  logic [WIN_WORDS-1:0][31:0] regView;
  logic                 rdHit;
  logic                 wrHit;
  logic                 wrEn;
  logic [IDX_W-1:0]     rdIdx;
  logic [IDX_W-1:0]     wrIdx;
  logic [31:0]          wrMerged;
  logic                 unusedBits;

  assign rdHit = (iwReadAddr[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]);
  assign wrHit = (iwWriteAddr[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]);
  assign rdIdx = iwReadAddr[WIN_BITS-1:2];
  assign wrIdx = iwWriteAddr[WIN_BITS-1:2];
  assign wrEn  = wrHit && (iwWstrb != 4'b0000);

  // Byte lanes [1:0] and unimplemented merged bits are intentionally dropped.
  assign unusedBits = ^{iwReadAddr[1:0], iwWriteAddr[1:0], wrMerged};

  // Read view of the whole window; unimplemented words and bits are zero.
  always_comb begin
    regView = '0;
    regView[IDX_CTRL][0]              = ctrlEn;
    regView[IDX_CTRL][16 +: PRESC_W]  = ctrlPresc;
    regView[IDX_MODE][2*NCH-1:0]      = modeReg;
    for (int c = 0; c < NCH; c++) begin
      if (IDX_DUTY0 + c < WIN_WORDS) begin
        regView[IDX_W'(IDX_DUTY0 + c)][PWM_W-1:0] = shadowDuty[c];
      end
    end
  end

  // Byte-strobe merge of the write data into the current register contents.
  always_comb begin
    wrMerged = regView[wrIdx];
    for (int b = 0; b < 4; b++) begin
      if (iwWstrb[b]) begin
        wrMerged[8*b +: 8] = iwWriteData[8*b +: 8];
      end
    end
  end

  // Configuration registers, updated from the merged write word.
  always_ff @(posedge iwClk) begin
    if (iwRst) begin
      ctrlEn    <= 1'b0;
      ctrlPresc <= '0;
      modeReg   <= '0;
      for (int c = 0; c < NCH; c++) begin
        shadowDuty[c] <= '0;
      end
    end else if (wrEn) begin
      if (wrIdx == IDX_CTRL) begin
        ctrlEn    <= wrMerged[0];
        ctrlPresc <= wrMerged[16 +: PRESC_W];
      end
      if (wrIdx == IDX_MODE) begin
        modeReg <= wrMerged[2*NCH-1:0];
      end
      for (int c = 0; c < NCH; c++) begin
        if (int'(wrIdx) == IDX_DUTY0 + c) begin
          shadowDuty[c] <= wrMerged[PWM_W-1:0];
        end
      end
    end
  end

  // Registered read data; sees pre-write contents on a same-cycle write.
  always_ff @(posedge iwClk) begin
    if (iwRst) begin
      owReadData <= '0;
    end else begin
      owReadData <= rdHit ? regView[rdIdx] : 32'h0;
    end
  end

  assign tick = ctrlEn && (prescCnt == ctrlPresc);
  assign wrap = tick && (pwmCnt == {PWM_W{1'b1}});

  // Prescaler: counts 0..PRESC, parked at zero while disabled.
  always_ff @(posedge iwClk) begin
    if (iwRst || !ctrlEn) begin
      prescCnt <= '0;
    end else if (tick) begin
      prescCnt <= '0;
    end else begin
      prescCnt <= prescCnt + 1'b1;
    end
  end

  // PWM counter advances once per tick and wraps naturally; frozen when disabled.
  always_ff @(posedge iwClk) begin
    if (iwRst) begin
      pwmCnt <= '0;
    end else if (tick) begin
      pwmCnt <= pwmCnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : gChan
    led_pwm_channel #(
      .PWM_W(PWM_W)
    ) uChan (
      .clk       (iwClk),
      .rst       (iwRst),
      .shadowDuty(shadowDuty[i]),
      .mode      (modeReg[2*i +: 2]),
      .cnt       (pwmCnt),
      .wrap      (wrap),
      .en        (ctrlEn),
      .nLed      (ownLed[i])
    );
  end

endmodule
